// File: rtl/fb_pkg.sv
// Shared widths, state encoding and write-request type for the frame-buffer arbiter.
// The 16-bit address is {y[7:0], x[7:0]} into a 256x256 x 3-bit pixel buffer.
package fb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 3;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  typedef enum logic {IDLE, CLEAR} fb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering pixel writes until the RAM port is free.
// Pointers carry one extra wrap bit so full and empty need no separate counter.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wr_req_t din,
  output wr_req_t dout,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(DEPTH);

  wr_req_t        entries [DEPTH];
  logic [PW:0]    wp, rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (push) entries[wp[PW-1:0]] <= din;
  end

  assign dout  = entries[rp[PW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: scanout read > clear sweep > buffered writes.
// RAM port outputs are combinational so a scan read issues in the cycle it is requested.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_rd_en,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  fb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_col;
  logic              cnt_step;
  logic              push, pop, full, empty;
  wr_req_t           head, req;

  assign scan_data = mem_rdata;
  assign wr_ready  = !full;
  assign push      = wr_valid && !full;
  assign req       = '{addr: wr_addr, data: wr_data};

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (req),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    cnt_step  = 1'b0;
    if (scan_rd_en) begin
      mem_en   = 1'b1;
      mem_addr = scan_addr;
    end
    case (state)
      IDLE: begin
        // A clear request beats queued writes so they land on the cleared image.
        if (clr_start) begin
          state_nxt = CLEAR;
        end else if (!scan_rd_en && !empty) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = head.addr;
          mem_wdata = head.data;
          pop       = 1'b1;
        end
      end
      CLEAR: begin
        if (!scan_rd_en) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = clr_cnt;
          mem_wdata = clr_col;
          cnt_step  = 1'b1;
          if (clr_cnt == CLR_LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_col  <= '0;
      clr_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_busy <= (state_nxt == CLEAR);
      if (state == IDLE && clr_start) begin
        clr_cnt <= '0;
        clr_col <= clr_color;
      end else if (cnt_step) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter with a behavioural RAM and a queue-based write model.
module tb_fb_arbiter;
  localparam int AW = 16;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          scan_rd_en = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic [DW-1:0] scan_data;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          clr_busy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  logic [DW-1:0]      ram [0:65535];
  logic [AW+DW-1:0]   wlog [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .scan_rd_en(scan_rd_en), .scan_addr(scan_addr), .scan_data(scan_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous RAM with 1-cycle read latency, plus a backdoor preload port and a write log.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] = pre_data;
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] = mem_wdata;
        wlog.push_back({mem_addr, mem_wdata});
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy got %b want 0", clr_busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (mem_en !== 1'b0 || clr_busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got en=%b busy=%b want 0 0", mem_en, clr_busy);
    end
  endtask

  task automatic scan_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d; scan_rd_en = 1'b0;
    @(negedge clk);
    pre_we = 1'b0; scan_rd_en = 1'b1; scan_addr = a;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a) begin
      errors++; $display("FAIL scan_issue got en=%b we=%b addr=%h want 1 0 %h", mem_en, mem_we, mem_addr, a);
    end
    @(negedge clk);
    scan_rd_en = 1'b0;
    checks++; if (scan_data !== d) begin
      errors++; $display("FAIL scan_data addr=%h got %b want %b", a, scan_data, d);
    end
  endtask

  task automatic test_scan_read();
    scan_one(16'h0A05, 3'b101);
    for (int i = 0; i < 6; i++) scan_one(AW'($urandom), DW'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [AW+DW-1:0] q [$];
    logic rdy;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      scan_rd_en = 1'b1; scan_addr = AW'($urandom);
      wr_valid = 1'b1; wr_addr = AW'($urandom); wr_data = DW'($urandom);
      #1;
      rdy = wr_ready;
      if (rdy) q.push_back({wr_addr, wr_data});
      checks++; if (rdy !== (i < 4)) begin
        errors++; $display("FAIL b2b_ready push=%0d got %b want %b", i, rdy, (i < 4));
      end
    end
    @(negedge clk);
    wr_valid = 1'b0; scan_rd_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || {mem_addr, mem_wdata} !== q[j]) begin
        errors++; $display("FAIL b2b_drain%0d got en=%b we=%b %h/%b want %h/%b", j, mem_en, mem_we,
                           mem_addr, mem_wdata, q[j][AW+DW-1:DW], q[j][DW-1:0]);
      end
    end
    @(negedge clk);
    #1;
    checks++; if (mem_en !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_empty got en=%b ready=%b want 0 1", mem_en, wr_ready);
    end
  endtask

  task automatic test_random_traffic();
    logic [AW+DW-1:0] q [$];
    int occ = 0;
    int bad = 0;
    bit exp_we;
    wlog.delete();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      scan_rd_en = 1'($urandom);
      scan_addr = AW'($urandom);
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_addr = AW'($urandom); wr_data = DW'($urandom);
      #1;
      exp_we = !scan_rd_en && occ > 0;
      if (wr_ready !== (occ < 4) || mem_we !== exp_we || (scan_rd_en && mem_addr !== scan_addr)) begin
        if (bad == 0) $display("FAIL rand_cycle c=%0d got ready=%b we=%b addr=%h want ready=%b we=%b",
                               c, wr_ready, mem_we, mem_addr, (occ < 4), exp_we);
        bad++;
      end
      if (wr_valid && occ < 4) begin q.push_back({wr_addr, wr_data}); occ++; end
      if (exp_we) occ--;
    end
    checks++; if (bad != 0) errors++;
    @(negedge clk);
    scan_rd_en = 1'b0; wr_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (wlog.size() != q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", wlog.size(), q.size());
    end else begin
      bad = 0;
      foreach (q[k]) if (wlog[k] !== q[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_order got %0d misordered want 0", bad); end
    end
  endtask

  task automatic test_clear_interleaved();
    logic [DW-1:0] col;
    int exp_a = 0;
    int bad = 0;
    col = DW'($urandom);
    @(negedge clk);
    clr_color = col; clr_start = 1'b1;
    for (int c = 0; c < 2 * 16'h1234; c++) begin
      @(negedge clk);
      clr_start = 1'b0;
      scan_rd_en = (c % 2 == 0); scan_addr = AW'($urandom);
      wr_valid = (c == 100); wr_addr = AW'($urandom); wr_data = DW'($urandom);
      #1;
      if (scan_rd_en) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== scan_addr) begin
          if (bad == 0) $display("FAIL ilv_scan c=%0d got en=%b we=%b addr=%h want 1 0 %h",
                                 c, mem_en, mem_we, mem_addr, scan_addr);
          bad++;
        end
      end else begin
        if (mem_we !== 1'b1 || mem_addr !== AW'(exp_a) || mem_wdata !== col) begin
          if (bad == 0) $display("FAIL ilv_sweep c=%0d got we=%b %h/%b want 1 %h/%b",
                                 c, mem_we, mem_addr, mem_wdata, AW'(exp_a), col);
          bad++;
        end
        exp_a++;
      end
      checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL ilv_busy c=%0d got 0 want 1", c); end
    end
    checks++; if (bad != 0) errors++;
    @(negedge clk);
    scan_rd_en = 1'b0; wr_valid = 1'b0; reset = 1'b1;
    #1;
    checks++; if (clr_busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL midsweep_reset got busy=%b en=%b want 0 0", clr_busy, mem_en);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++; if (clr_busy !== 1'b0 || mem_en !== 1'b0 || wr_ready !== 1'b1) begin
        errors++; $display("FAIL after_reset%0d got busy=%b en=%b ready=%b want 0 0 1",
                           k, clr_busy, mem_en, wr_ready);
      end
    end
  endtask

  task automatic test_clear_full();
    int n = 0;
    int bad = 0;
    wlog.delete();
    @(negedge clk);
    clr_color = 3'b010; clr_start = 1'b1; scan_rd_en = 1'b0;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clr_busy_start got 1 want 0"); end
    while (n < 70000) begin
      @(negedge clk);
      clr_start = (n == 2000);
      if (n == 2000) clr_color = 3'b101;
      wr_valid = (n == 1000); wr_addr = 16'h0100; wr_data = 3'b111;
      if (!clr_busy) break;
      n++;
    end
    clr_start = 1'b0; wr_valid = 1'b0;
    checks++; if (n != 65536) begin errors++; $display("FAIL clr_duration got %0d want 65536", n); end
    repeat (4) @(negedge clk);
    checks++; if (wlog.size() != 65537) begin
      errors++; $display("FAIL clr_write_count got %0d want 65537", wlog.size());
    end else begin
      for (int a = 0; a < 65536; a++) if (wlog[a] !== {AW'(a), 3'b010}) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL clr_sequence got %0d bad want 0", bad); end
      checks++; if (wlog[65536] !== {16'h0100, 3'b111}) begin
        errors++; $display("FAIL clr_queued_write got %h want %h", wlog[65536], {16'h0100, 3'b111});
      end
    end
    bad = 0;
    for (int a = 0; a < 65536; a++) if (ram[a] !== ((a == 16'h0100) ? 3'b111 : 3'b010)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_image got %0d bad pixels want 0", bad); end
    checks++; if (clr_busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL clr_done got busy=%b en=%b want 0 0", clr_busy, mem_en);
    end
  endtask

  initial begin
    test_reset();
    test_scan_read();
    test_back_to_back();
    test_random_traffic();
    test_clear_interleaved();
    test_clear_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
